// File: rtl/fp_normalize.sv
// Iterative post-add normalizer: carry right-shift, one left shift per clock, exponent fix-up.
// Latency 1+N cycles after acceptance (N = left shifts); results hold in DONE until out_ready.
module fp_normalize #(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] sum_mant,
  input  logic [7:0]  exp_in,
  input  logic        sign_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] mantisa_norm,
  output logic [7:0]  exp_norm,
  output logic        sign_norm,
  output logic        zero_flag,
  output logic        ovf_flag,
  output logic        unf_flag
);

  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t        state, state_nx;
  logic [27:0]   m, m_nx;
  logic [7:0]    e, e_nx;
  logic [7:0]    e_inc;
  logic          s, s_nx;
  logic          zero, zero_nx;
  logic          ovf, ovf_nx;
  logic          unf, unf_nx;
  logic [CW-1:0] cnt, cnt_nx;

  assign e_inc = e + 8'd1;

  always_comb begin
    state_nx = state;
    m_nx     = m;
    e_nx     = e;
    s_nx     = s;
    zero_nx  = zero;
    ovf_nx   = ovf;
    unf_nx   = unf;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          m_nx     = sum_mant;
          e_nx     = exp_in;
          s_nx     = sign_in;
          zero_nx  = 1'b0;
          ovf_nx   = 1'b0;
          unf_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = NORM;
        end
      end
      NORM: begin
        if (e == 8'd255) begin
          ovf_nx   = 1'b1;
          state_nx = DONE;
        end else if (m == 28'd0) begin
          zero_nx  = 1'b1;
          e_nx     = 8'd0;
          state_nx = DONE;
        end else if (m[27]) begin
          // Right shift folds the dropped bit into sticky.
          m_nx     = {1'b0, m[27:2], m[1] | m[0]};
          e_nx     = e_inc;
          if (e_inc == 8'd255) begin
            ovf_nx       = 1'b1;
            m_nx[26:0]   = 27'd0;
          end
          state_nx = DONE;
        end else if (m[26]) begin
          state_nx = DONE;
        end else if (e <= 8'd1) begin
          unf_nx   = 1'b1;
          e_nx     = 8'd0;
          state_nx = DONE;
        end else if (cnt == MAX_SHIFT[CW-1:0]) begin
          state_nx = DONE;
        end else begin
          m_nx     = {m[26:0], 1'b0};
          e_nx     = e - 8'd1;
          cnt_nx   = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      e     <= '0;
      s     <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      m     <= m_nx;
      e     <= e_nx;
      s     <= s_nx;
      zero  <= zero_nx;
      ovf   <= ovf_nx;
      unf   <= unf_nx;
      cnt   <= cnt_nx;
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign mantisa_norm = m[26:0];
  assign exp_norm     = e;
  assign sign_norm    = s;
  assign zero_flag    = zero;
  assign ovf_flag     = ovf;
  assign unf_flag     = unf;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed table-driven bench for fp_normalize, plus backpressure and mid-flight reset sequences.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] sum_mant;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] mantisa_norm;
  logic [7:0]  exp_norm;
  logic        sign_norm;
  logic        zero_flag;
  logic        ovf_flag;
  logic        unf_flag;

  int checks = 0;
  int errors = 0;

  fp_normalize #(.MAX_SHIFT(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_mant(sum_mant), .exp_in(exp_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mantisa_norm(mantisa_norm), .exp_norm(exp_norm), .sign_norm(sign_norm),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] sum;
    logic [7:0]  ex;
    logic        sg;
    logic [26:0] mant;
    logic [7:0]  eo;
    logic        so;
    logic [2:0]  flags;  // {zero, ovf, unf}
    int          lat;    // edges from accept to out_valid (1+N)
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Accept one sum, wait for the result, check it, optionally hold backpressure, then drain.
  task automatic run_vec(input vec_t v, input int idx, input int hold);
    int cyc;
    logic [26:0] m0;
    logic [7:0]  e0;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; sum_mant = v.sum; exp_in = v.ex; sign_in = v.sg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
    chk($sformatf("v%0d latency", idx), cyc, v.lat);
    chk($sformatf("v%0d mant", idx), {5'd0, mantisa_norm}, {5'd0, v.mant});
    chk($sformatf("v%0d exp", idx), {24'd0, exp_norm}, {24'd0, v.eo});
    chk($sformatf("v%0d sign", idx), {31'd0, sign_norm}, {31'd0, v.so});
    chk($sformatf("v%0d flags", idx), {29'd0, zero_flag, ovf_flag, unf_flag}, {29'd0, v.flags});
    m0 = mantisa_norm; e0 = exp_norm;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d bp valid", idx), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d bp in_ready", idx), {31'd0, in_ready}, 32'd0);
      chk($sformatf("v%0d bp stable", idx), {mantisa_norm == m0 && exp_norm == e0}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d drained", idx), {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{28'h8000004, 8'd127, 1'b0, 27'h4000002, 8'd128, 1'b0, 3'b000, 1};
    vecs[1]  = '{28'h4000005, 8'd100, 1'b1, 27'h4000005, 8'd100, 1'b1, 3'b000, 1};
    vecs[2]  = '{28'h0000008, 8'd127, 1'b0, 27'h4000000, 8'd104, 1'b0, 3'b000, 24};
    vecs[3]  = '{28'h0100000, 8'd2,   1'b0, 27'h0200000, 8'd0,   1'b0, 3'b001, 2};
    vecs[4]  = '{28'h0000000, 8'd50,  1'b1, 27'h0000000, 8'd0,   1'b1, 3'b100, 1};
    vecs[5]  = '{28'h8000000, 8'd254, 1'b0, 27'h0000000, 8'd255, 1'b0, 3'b010, 1};
    vecs[6]  = '{28'h8000003, 8'd255, 1'b1, 27'h0000003, 8'd255, 1'b1, 3'b010, 1};
    vecs[7]  = '{28'h8000001, 8'd10,  1'b0, 27'h4000001, 8'd11,  1'b0, 3'b000, 1};
    vecs[8]  = '{28'h0800000, 8'd1,   1'b0, 27'h0800000, 8'd0,   1'b0, 3'b001, 1};
    vecs[9]  = '{28'h1000007, 8'd50,  1'b1, 27'h400001C, 8'd48,  1'b1, 3'b000, 3};
    vecs[10] = '{28'h8000000, 8'd0,   1'b0, 27'h4000000, 8'd1,   1'b0, 3'b000, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sum_mant = '0; exp_in = '0; sign_in = 1'b0;
    #12;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset outputs", {mantisa_norm, exp_norm, sign_norm, zero_flag, ovf_flag, unf_flag} == '0, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i, 0);

    // Backpressure: result must hold for 5 cycles with out_ready low.
    run_vec(vecs[9], 100, 5);

    // Reset three cycles into the cancellation case must abort it.
    @(negedge clk);
    in_valid = 1'b1; sum_mant = 28'h0000008; exp_in = 8'd127; sign_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst outputs", {mantisa_norm, exp_norm, sign_norm, zero_flag, ovf_flag, unf_flag} == '0, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk("no stale result", {31'd0, out_valid}, 32'd0);
    run_vec(vecs[0], 200, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
